// File: rtl/sum_checker_if.sv
// Bus between an adder under test and its sum_checker: operand/result taps in,
// verdict counters and first-failure capture out.
interface sum_checker_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             start;
    logic             stop;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             fail_seen;
    logic [WIDTH-1:0] ff_a;
    logic [WIDTH-1:0] ff_b;
    logic [WIDTH-1:0] ff_y;
    logic [WIDTH-1:0] ff_exp;
    logic [CNT_W-1:0] carry_cnt;

    modport master (
        output start, stop, in_valid, a, b, y,
        input  busy, done, pass_cnt, fail_cnt, fail_seen,
               ff_a, ff_b, ff_y, ff_exp, carry_cnt
    );

    modport slave (
        input  start, stop, in_valid, a, b, y,
        output busy, done, pass_cnt, fail_cnt, fail_seen,
               ff_a, ff_b, ff_y, ff_exp, carry_cnt
    );
endinterface

// File: rtl/sum_checker.sv
// Adder result checker: operands ride a LATENCY-deep tag pipeline and are compared with y
// at the matching edge. Optional wrapped-sum counter under SUM_CHECKER_CARRY_CNT_EN.
module sum_checker #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    sum_checker_if.slave  bus
);
    localparam int DW = 4;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state;
    logic [DW-1:0]    drain_cnt;
    logic             busy_q;
    logic             done_q;
    logic [LATENCY-1:0] pv;
    logic [WIDTH-1:0] pa [LATENCY];
    logic [WIDTH-1:0] pb [LATENCY];
    logic [CNT_W-1:0] pass_q;
    logic [CNT_W-1:0] fail_q;
    logic             seen_q;
    logic [WIDTH-1:0] fa_q, fb_q, fy_q, fe_q;

    logic [WIDTH-1:0] exp_sum;
    logic             match;
    logic             accept;

    assign exp_sum = pa[LATENCY-1] + pb[LATENCY-1];
    // Case equality so an X/Z on y is scored as a mismatch.
    assign match   = (bus.y === exp_sum);
    assign accept  = (state == RUN) && bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            drain_cnt <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pv        <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pa[i] <= '0;
                pb[i] <= '0;
            end
            pass_q <= '0;
            fail_q <= '0;
            seen_q <= 1'b0;
            fa_q   <= '0;
            fb_q   <= '0;
            fy_q   <= '0;
            fe_q   <= '0;
        end else begin
            done_q <= 1'b0;
            for (int i = LATENCY - 1; i > 0; i--) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
                pb[i] <= pb[i-1];
            end
            pv[0] <= accept;
            pa[0] <= bus.a;
            pb[0] <= bus.b;

            if (bus.start) begin
                // start wins over stop and over any compare landing this edge
                state  <= RUN;
                busy_q <= 1'b1;
                pv     <= '0;
                pass_q <= '0;
                fail_q <= '0;
                seen_q <= 1'b0;
                fa_q   <= '0;
                fb_q   <= '0;
                fy_q   <= '0;
                fe_q   <= '0;
            end else begin
                if (pv[LATENCY-1]) begin
                    if (match) begin
                        if (pass_q != '1) pass_q <= pass_q + CNT_W'(1);
                    end else begin
                        if (fail_q != '1) fail_q <= fail_q + CNT_W'(1);
                        if (!seen_q) begin
                            seen_q <= 1'b1;
                            fa_q   <= pa[LATENCY-1];
                            fb_q   <= pb[LATENCY-1];
                            fy_q   <= bus.y;
                            fe_q   <= exp_sum;
                        end
                    end
                end

                case (state)
                    RUN: begin
                        if (bus.stop) begin
                            state     <= DRAIN;
                            drain_cnt <= DW'(LATENCY - 1);
                            done_q    <= (LATENCY == 1);
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt == '0) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            drain_cnt <= drain_cnt - DW'(1);
                            done_q    <= (drain_cnt == DW'(1));
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SUM_CHECKER_CARRY_CNT_EN
    logic [WIDTH:0]   full_sum;
    logic [CNT_W-1:0] carry_q;

    assign full_sum = {1'b0, pa[LATENCY-1]} + {1'b0, pb[LATENCY-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= '0;
        end else if (bus.start) begin
            carry_q <= '0;
        end else if (pv[LATENCY-1] && full_sum[WIDTH] && (carry_q != '1)) begin
            carry_q <= carry_q + CNT_W'(1);
        end
    end

    assign bus.carry_cnt = carry_q;
`else
    assign bus.carry_cnt = '0;
`endif

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass_cnt  = pass_q;
    assign bus.fail_cnt  = fail_q;
    assign bus.fail_seen = seen_q;
    assign bus.ff_a      = fa_q;
    assign bus.ff_b      = fb_q;
    assign bus.ff_y      = fy_q;
    assign bus.ff_exp    = fe_q;
endmodule
